// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: FSM state encoding,
// datapath select encodings, instruction field codes and the condition
// evaluator used by the cond_logic block.
package multicycle_controller_pkg;

  // FSM states. The numeric encoding is visible on the State debug output.
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } stateT;

  // ALUControl encodings
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_EOR = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  // Instruction op field
  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  // Data-processing cmd field (funct[4:1])
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  // Condition field codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Evaluate an ARM condition code against flags {N,Z,C,V}.
  // The reserved code 1111 never executes.
  function automatic logic condHolds(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, result;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      COND_EQ: result = z;
      COND_NE: result = ~z;
      COND_CS: result = c;
      COND_CC: result = ~c;
      COND_MI: result = n;
      COND_PL: result = ~n;
      COND_VS: result = v;
      COND_VC: result = ~v;
      COND_HI: result = c & ~z;
      COND_LS: result = ~c | z;
      COND_GE: result = (n == v);
      COND_LT: result = (n != v);
      COND_GT: result = ~z & (n == v);
      COND_LE: result = z | (n != v);
      COND_AL: result = 1'b1;
      COND_NV: result = 1'b0;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Bus between the multicycle controller and its datapath.
//   Instr      : instruction bits [31:12] (cond, op, funct, Rn, Rd)
//   ALUFlags   : {N,Z,C,V} from the ALU
//   PCWrite .. ALUControl : datapath enables and selects
//   State      : current controller state (debug)
// The slave modport is the controller; the master modport is the datapath.
interface multicycle_controller_if;

  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  RegSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  ALUControl;
  logic [3:0]  State;

  modport master (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
    input  ALUSrcA, ALUSrcB, RegSrc, ImmSrc, ALUControl, State
  );

  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
    output ALUSrcA, ALUSrcB, RegSrc, ImmSrc, ALUControl, State
  );

endinterface

// File: rtl/multicycle_controller_cond_logic.sv
// Conditional-execution block: stored {N,Z,C,V} flags, the per-instruction
// CondEx bit and the condition evaluator.
//   clk, reset   : clock, asynchronous active-low reset
//   cond         : instruction condition field
//   aluFlags     : live ALU flags
//   condExLoad   : capture CondEx at the end of DECODE
//   condExClear  : drop CondEx at the end of FETCH
//   flagWe       : [1] update N,Z  [0] update C,V (already qualified by S)
//   condEx       : registered condition result for the current instruction
//   flags        : stored flags
module cond_logic
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] aluFlags,
  input  logic       condExLoad,
  input  logic       condExClear,
  input  logic [1:0] flagWe,
  output logic       condEx,
  output logic [3:0] flags
);

  // CondEx is sampled once from the flags as they stand before the
  // instruction, so a flag update later in the same instruction cannot
  // change its own execution decision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      condEx <= 1'b0;
    end else if (condExLoad) begin
      condEx <= condHolds(cond, flags);
    end else if (condExClear) begin
      condEx <= 1'b0;
    end else begin
      condEx <= condEx;
    end
  end

  // Flags only change for an executed instruction; N/Z and C/V have
  // separate enables because logical ops keep the carry and overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= 4'b0000;
    end else begin
      if (condEx && flagWe[1]) begin
        flags[3:2] <= aluFlags[3:2];
      end else begin
        flags[3:2] <= flags[3:2];
      end
      if (condEx && flagWe[0]) begin
        flags[1:0] <= aluFlags[1:0];
      end else begin
        flags[1:0] <= flags[1:0];
      end
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset controller: main FSM, data-processing decoder and
// output generation, with conditional execution delegated to cond_logic.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of multicycle_controller_if (Instr/ALUFlags in,
//           datapath enables/selects and debug State out)
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.slave bus
);

  stateT      state;
  stateT      nextState;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       unusedRn;

  logic [1:0] decAluControl;
  logic       noWrite;
  logic       nzUpd;
  logic       cvUpd;
  logic       sBit;
  logic [1:0] flagWe;
  logic       condEx;
  logic [3:0] storedFlags;

  logic       pcWrite;
  logic       adrSrc;
  logic       memWrite;
  logic       irWrite;
  logic       regWrite;
  logic [1:0] resultSrc;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluControl;

  assign cond     = bus.Instr[19:16];
  assign op       = bus.Instr[15:14];
  assign funct    = bus.Instr[13:8];
  assign rd       = bus.Instr[3:0];
  assign cmd      = funct[4:1];
  assign unusedRn = ^bus.Instr[7:4];

  // Data-processing decode. Unknown commands run as ADD but never write
  // a register or the flags.
  always_comb begin
    decAluControl = ALU_ADD;
    noWrite       = 1'b0;
    nzUpd         = 1'b0;
    cvUpd         = 1'b0;
    case (cmd)
      CMD_ADD: begin decAluControl = ALU_ADD; nzUpd = 1'b1; cvUpd = 1'b1; end
      CMD_SUB: begin decAluControl = ALU_SUB; nzUpd = 1'b1; cvUpd = 1'b1; end
      CMD_EOR: begin decAluControl = ALU_EOR; nzUpd = 1'b1; end
      CMD_AND: begin decAluControl = ALU_AND; nzUpd = 1'b1; end
      CMD_CMP: begin decAluControl = ALU_SUB; nzUpd = 1'b1; cvUpd = 1'b1; noWrite = 1'b1; end
      default: begin decAluControl = ALU_ADD; noWrite = 1'b1; end
    endcase
  end

  // CMP always sets flags regardless of its S bit.
  assign sBit = funct[0] | (cmd == CMD_CMP);

  // Flag enables are only live in the execute states, so the update lands
  // on the EXECR/EXECI -> ALUWB edge.
  always_comb begin
    flagWe = 2'b00;
    if ((state == EXECR) || (state == EXECI)) begin
      flagWe = {nzUpd & sBit, cvUpd & sBit};
    end else begin
      flagWe = 2'b00;
    end
  end

  cond_logic uCondLogic (
    .clk         (clk),
    .reset       (reset),
    .cond        (cond),
    .aluFlags    (bus.ALUFlags),
    .condExLoad  (state == DECODE),
    .condExClear (state == FETCH),
    .flagWe      (flagWe),
    .condEx      (condEx),
    .flags       (storedFlags)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = FETCH;
    case (state)
      FETCH:  nextState = DECODE;
      DECODE: begin
        case (op)
          OP_MEM:   nextState = MEMADR;
          OP_DP:    nextState = funct[5] ? EXECI : EXECR;
          OP_BR:    nextState = BRANCH;
          OP_UNDEF: nextState = FETCH;
          default:  nextState = FETCH;
        endcase
      end
      MEMADR: nextState = funct[0] ? MEMRD : MEMWR;
      MEMRD:  nextState = MEMWB;
      EXECR:  nextState = ALUWB;
      EXECI:  nextState = ALUWB;
      MEMWB:  nextState = FETCH;
      MEMWR:  nextState = FETCH;
      ALUWB:  nextState = FETCH;
      BRANCH: nextState = FETCH;
      default: nextState = FETCH;
    endcase
  end

  // Per-state enables and selects (Moore, except for the CondEx gating)
  always_comb begin
    pcWrite    = 1'b0;
    adrSrc     = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    regWrite   = 1'b0;
    resultSrc  = RES_ALUOUT;
    aluSrcA    = 1'b0;
    aluSrcB    = SRCB_RD2;
    aluControl = ALU_ADD;
    case (state)
      FETCH: begin
        irWrite   = 1'b1;
        pcWrite   = 1'b1;
        aluSrcA   = 1'b1;
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALURESULT;
      end
      DECODE: begin
        aluSrcA   = 1'b1;
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALURESULT;
      end
      MEMADR: aluSrcB = SRCB_EXTIMM;
      MEMRD:  adrSrc  = 1'b1;
      MEMWB: begin
        resultSrc = RES_DATA;
        regWrite  = condEx;
      end
      MEMWR: begin
        adrSrc   = 1'b1;
        memWrite = condEx;
      end
      EXECR: begin
        aluSrcB    = SRCB_RD2;
        aluControl = decAluControl;
      end
      EXECI: begin
        aluSrcB    = SRCB_EXTIMM;
        aluControl = decAluControl;
      end
      ALUWB: begin
        regWrite = condEx & ~noWrite;
        pcWrite  = condEx & ~noWrite & (rd == 4'd15);
      end
      BRANCH: begin
        aluSrcB   = SRCB_EXTIMM;
        resultSrc = RES_ALURESULT;
        pcWrite   = condEx;
      end
      default: begin
        pcWrite = 1'b0;
      end
    endcase
  end

  // Everything is forced idle straight from the reset pin so that no
  // enable can glitch high during the reset cycle, even though FETCH
  // itself asserts PCWrite/IRWrite.
  assign bus.PCWrite    = reset & pcWrite;
  assign bus.AdrSrc     = reset & adrSrc;
  assign bus.MemWrite   = reset & memWrite;
  assign bus.IRWrite    = reset & irWrite;
  assign bus.RegWrite   = reset & regWrite;
  assign bus.ResultSrc  = reset ? resultSrc : RES_ALUOUT;
  assign bus.ALUSrcA    = reset & aluSrcA;
  assign bus.ALUSrcB    = reset ? aluSrcB : SRCB_RD2;
  assign bus.ALUControl = reset ? aluControl : ALU_ADD;
  assign bus.ImmSrc     = reset ? op : 2'b00;
  assign bus.RegSrc     = reset ? {op == OP_MEM, op == OP_BR} : 2'b00;
  assign bus.State      = state;

endmodule
